// File: rtl/count_pkg.sv
// Shared types and the modulus/saturate step rule for the up/down counter.
// Arithmetic is carried in 32 bits so one function serves every WIDTH up to 32.
package count_pkg;

    typedef enum logic [1:0] {
        HOLD,
        INC,
        DEC
    } step_t;

    typedef struct packed {
        logic [31:0] count;
        logic        carry;
        logic        borrow;
    } step_res_t;

    // Saturate mode still reports the terminal event even though the count holds.
    function automatic step_res_t next_count(
        input logic [31:0] cur,
        input step_t       step,
        input logic [31:0] max_count,
        input logic        saturate
    );
        step_res_t res;
        res.count  = cur;
        res.carry  = 1'b0;
        res.borrow = 1'b0;
        case (step)
            INC: begin
                if (cur == max_count) begin
                    res.carry = 1'b1;
                    res.count = saturate ? max_count : 32'd0;
                end else begin
                    res.count = cur + 32'd1;
                end
            end
            DEC: begin
                if (cur == 32'd0) begin
                    res.borrow = 1'b1;
                    res.count  = saturate ? 32'd0 : max_count;
                end else begin
                    res.count = cur - 32'd1;
                end
            end
            default: ;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/prescaler.sv
// Divides enabled cycles by PRESCALE into single-cycle ticks.
// A low enable freezes the phase; clear restarts it from zero.
module prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int PHASE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = ^{clock, reset, clear};
            assign tick          = enable;
        end else begin : g_count
            localparam logic [PHASE_W-1:0] LAST = PHASE_W'(PRESCALE - 1);

            logic [PHASE_W-1:0] phase_q;
            logic [PHASE_W-1:0] phase_d;

            assign tick = enable && (phase_q == LAST);

            // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
            always_comb begin
                phase_d = phase_q;
                if (clear || tick) begin
                    phase_d = '0;
                end else if (enable) begin
                    phase_d = phase_q + 1'b1;
                end
            end

            // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/updown_count.sv
// Parametrised up/down counter with parallel load, wrap/saturate mode,
// enable prescaler and carry/borrow/sticky-overflow status.
module updown_count
    import count_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 2 ** WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             saturate,
    input  logic             clear_overflow,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             borrow,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    logic             tick;
    step_t            step;
    step_res_t        res;

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             overflow_q, overflow_d;

    // Load restarts the prescaler so the next step needs a full PRESCALE enabled cycles.
    prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .clear (load),
        .tick  (tick)
    );

    always_comb begin
        step = HOLD;
        if (tick && up && !down) begin
            step = INC;
        end else if (tick && down && !up) begin
            step = DEC;
        end
    end

    always_comb begin
        res      = next_count(32'(count_q), step, 32'(MAX_COUNT), saturate);
        count_d  = WIDTH'(res.count);
        carry_d  = res.carry;
        borrow_d = res.borrow;
        if (load) begin
            count_d  = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
            carry_d  = 1'b0;
            borrow_d = 1'b0;
        end
        // A terminal event outranks a simultaneous clear request.
        overflow_d = overflow_q;
        if (carry_d || borrow_d) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign carry    = carry_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;

endmodule
